// File: rtl/dma_engine_if.sv
// rtl/dma_engine_if.sv - shared addr/data/w_notr bus plus the engine's ownership and done flags
interface dma_engine_if #(
  parameter int SZ  = 8,
  parameter int WSZ = 8
);
  wire  [SZ-1:0]  addr;
  wire  [WSZ-1:0] data;
  wire            w_notr;
  logic           interrupt;
  logic           done;

  modport master (
    output interrupt,
    output done,
    inout  addr,
    inout  data,
    inout  w_notr
  );

  modport slave (
    input  interrupt,
    input  done,
    inout  addr,
    inout  data,
    inout  w_notr
  );
endinterface

// File: rtl/dma_engine.sv
// rtl/dma_engine.sv - bus-programmed DMA engine: register responder when idle, word copier while it owns the bus
module dma_engine #(
  parameter int            SZ   = 8,
  parameter int            WSZ  = 8,
  parameter logic [SZ-1:0] BASE = 8'hF0
) (
  input  logic         clk,
  input  logic         rst,
  dma_engine_if.master bus
);
  typedef enum logic [2:0] {IDLE, ARB, RD, WR, FIN} state_t;

  state_t         state;
  logic [SZ-1:0]  dev_reg, len_reg, mem_reg;
  logic [SZ-1:0]  dev_cnt, mem_cnt, remain;
  logic [SZ-1:0]  drv_addr;
  logic [WSZ-1:0] hold, rd_val;
  logic           dir, start_q, irq_q, done_q;
  logic           addr_en, data_en, drv_wr;
  logic           in_win, rd_en, wr_req, busy;

  assign in_win = (bus.addr[SZ-1:2] == BASE[SZ-1:2]);
  assign busy   = (state == ARB) || (state == RD) || (state == WR);
  assign rd_en  = !irq_q && (bus.w_notr == 1'b0) && in_win;
  assign wr_req = (state == IDLE) && (bus.w_notr == 1'b1) && in_win;

  always_comb begin
    rd_val = '0;
    case (bus.addr[1:0])
      2'd0: rd_val = WSZ'(dev_reg);
      2'd1: rd_val = WSZ'(len_reg);
      2'd2: rd_val = WSZ'(mem_reg);
      default: begin
        rd_val[0]     = dir;
        rd_val[WSZ-1] = busy;
      end
    endcase
  end

  assign bus.addr      = addr_en ? drv_addr : 'z;
  assign bus.w_notr    = addr_en ? drv_wr : 1'bz;
  assign bus.data      = rd_en ? rd_val : (data_en ? hold : 'z);
  assign bus.interrupt = irq_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dev_reg  <= '0;
      len_reg  <= '0;
      mem_reg  <= '0;
      dir      <= 1'b0;
      start_q  <= 1'b0;
      dev_cnt  <= '0;
      mem_cnt  <= '0;
      remain   <= '0;
      hold     <= '0;
      irq_q    <= 1'b0;
      done_q   <= 1'b0;
      addr_en  <= 1'b0;
      data_en  <= 1'b0;
      drv_wr   <= 1'b0;
      drv_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          // start is taken one cycle after the ctrl write so interrupt rises at N+1
          if (start_q) begin
            start_q <= 1'b0;
            state   <= ARB;
            irq_q   <= 1'b1;
            dev_cnt <= dev_reg;
            mem_cnt <= mem_reg;
            remain  <= len_reg;
          end else if (wr_req) begin
            case (bus.addr[1:0])
              2'd0: dev_reg <= SZ'(bus.data);
              2'd1: len_reg <= SZ'(bus.data);
              2'd2: mem_reg <= SZ'(bus.data);
              default: begin
                dir     <= bus.data[0];
                start_q <= bus.data[1];
              end
            endcase
          end
        end
        ARB: begin
          if (remain != '0) begin
            state    <= RD;
            addr_en  <= 1'b1;
            drv_wr   <= 1'b0;
            drv_addr <= dir ? mem_cnt : dev_cnt;
          end else begin
            state  <= FIN;
            irq_q  <= 1'b0;
            done_q <= 1'b1;
          end
        end
        RD: begin
          hold     <= bus.data;
          state    <= WR;
          drv_wr   <= 1'b1;
          data_en  <= 1'b1;
          drv_addr <= dir ? dev_cnt : mem_cnt;
        end
        WR: begin
          dev_cnt <= dev_cnt + SZ'(1);
          mem_cnt <= mem_cnt + SZ'(1);
          remain  <= remain - SZ'(1);
          data_en <= 1'b0;
          if (remain > SZ'(1)) begin
            state    <= RD;
            drv_wr   <= 1'b0;
            drv_addr <= dir ? (mem_cnt + SZ'(1)) : (dev_cnt + SZ'(1));
          end else begin
            state   <= FIN;
            addr_en <= 1'b0;
            irq_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_engine.sv
// tb/tb_dma_engine.sv - directed bench for dma_engine acting as CPU, memory and device on the shared bus
module tb_dma_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_engine_if #(.SZ(8), .WSZ(8)) bus_if ();

  dma_engine #(.SZ(8), .WSZ(8), .BASE(8'hF0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic       cpu_drv = 1'b0;
  logic       cpu_w   = 1'b0;
  logic [7:0] cpu_addr = 8'h00;
  logic [7:0] cpu_data = 8'h00;
  logic [7:0] init_mem [256];
  logic       dev_drv;

  // memory and devices share one address space and answer engine read cycles
  assign dev_drv       = bus_if.interrupt && (bus_if.w_notr === 1'b0);
  assign bus_if.addr   = cpu_drv ? cpu_addr : 'z;
  assign bus_if.w_notr = cpu_drv ? cpu_w : 1'bz;
  assign bus_if.data   = (cpu_drv && cpu_w) ? cpu_data : (dev_drv ? init_mem[bus_if.addr] : 'z);

  logic [16:0] log_q [$];
  int          int_cyc = 0;

  always @(negedge clk) begin
    if (bus_if.interrupt) begin
      if (int_cyc > 0) log_q.push_back({bus_if.w_notr, bus_if.addr, bus_if.data});
      int_cyc <= int_cyc + 1;
    end else begin
      int_cyc <= 0;
    end
  end

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [16:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_drv = 1'b1; cpu_w = 1'b1; cpu_addr = a; cpu_data = d;
    @(negedge clk);
    cpu_drv = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    cpu_drv = 1'b1; cpu_w = 1'b0; cpu_addr = a;
    #1;
    d = bus_if.data;
    cpu_drv = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output logic int1);
    cyc = 0;
    int1 = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) int1 = bus_if.interrupt;
    end while (!bus_if.done && cyc < 60);
  endtask

  task automatic check_log(input string tag, input int base);
    check({tag, "_count"}, log_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < log_q.size()) check($sformatf("%s_%0d", tag, i), log_q[base + i], exp_q[i]);
  endtask

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] v;
    cpu_read(8'hF0, v); check({tag, "_dev"}, v, e0);
    cpu_read(8'hF1, v); check({tag, "_len"}, v, e1);
    cpu_read(8'hF2, v); check({tag, "_mem"}, v, e2);
    cpu_read(8'hF3, v); check({tag, "_ctrl"}, v, e3);
  endtask

  int   cyc;
  int   base;
  logic int1;

  initial begin
    for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
    init_mem[8'h40] = 8'h11; init_mem[8'h41] = 8'h22; init_mem[8'h42] = 8'h33;
    init_mem[8'h20] = 8'hA5; init_mem[8'h21] = 8'h5A;
    init_mem[8'hFF] = 8'hC1; init_mem[8'h00] = 8'hC2; init_mem[8'h01] = 8'hC3;
    init_mem[8'h90] = 8'h77; init_mem[8'h91] = 8'h88;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_int", bus_if.interrupt, 1'b0);
    check("rst_done", bus_if.done, 1'b0);
    rst = 1'b0;
    check_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00);

    // memory 40.. -> device 10.., three words
    cpu_write(8'hF0, 8'h10); cpu_write(8'hF1, 8'h03); cpu_write(8'hF2, 8'h40);
    base = log_q.size();
    cpu_write(8'hF3, 8'h03);
    check("m2d_int_n0", bus_if.interrupt, 1'b0);
    wait_done(cyc, int1);
    check("m2d_int_n1", int1, 1'b1);
    check("m2d_done_cyc", cyc, 8);
    check("m2d_int_fall", bus_if.interrupt, 1'b0);
    @(negedge clk);
    check("m2d_done_pulse", bus_if.done, 1'b0);
    exp_q = '{{1'b0, 8'h40, 8'h11}, {1'b1, 8'h10, 8'h11}, {1'b0, 8'h41, 8'h22},
              {1'b1, 8'h11, 8'h22}, {1'b0, 8'h42, 8'h33}, {1'b1, 8'h12, 8'h33}};
    check_log("m2d", base);
    check_regs("m2d", 8'h10, 8'h03, 8'h40, 8'h01);

    // device 20.. -> memory 80.., two words
    cpu_write(8'hF0, 8'h20); cpu_write(8'hF1, 8'h02); cpu_write(8'hF2, 8'h80);
    base = log_q.size();
    cpu_write(8'hF3, 8'h02);
    wait_done(cyc, int1);
    check("d2m_int_n1", int1, 1'b1);
    check("d2m_done_cyc", cyc, 6);
    exp_q = '{{1'b0, 8'h20, 8'hA5}, {1'b1, 8'h80, 8'hA5},
              {1'b0, 8'h21, 8'h5A}, {1'b1, 8'h81, 8'h5A}};
    check_log("d2m", base);
    check_regs("d2m", 8'h20, 8'h02, 8'h80, 8'h00);

    // zero length: one ARB cycle, no bus traffic
    cpu_write(8'hF1, 8'h00);
    base = log_q.size();
    cpu_write(8'hF3, 8'h02);
    wait_done(cyc, int1);
    check("len0_int_n1", int1, 1'b1);
    check("len0_done_cyc", cyc, 2);
    check("len0_int_fall", bus_if.interrupt, 1'b0);
    exp_q = {};
    check_log("len0", base);

    // address counters wrap through FF -> 00
    cpu_write(8'hF0, 8'hFE); cpu_write(8'hF1, 8'h03); cpu_write(8'hF2, 8'hFF);
    base = log_q.size();
    cpu_write(8'hF3, 8'h03);
    wait_done(cyc, int1);
    check("wrap_done_cyc", cyc, 8);
    exp_q = '{{1'b0, 8'hFF, 8'hC1}, {1'b1, 8'hFE, 8'hC1}, {1'b0, 8'h00, 8'hC2},
              {1'b1, 8'hFF, 8'hC2}, {1'b0, 8'h01, 8'hC3}, {1'b1, 8'h00, 8'hC3}};
    check_log("wrap", base);

    // reset during the second write cycle
    cpu_write(8'hF0, 8'h10); cpu_write(8'hF1, 8'h03); cpu_write(8'hF2, 8'h40);
    base = log_q.size();
    cpu_write(8'hF3, 8'h03);
    repeat (5) @(negedge clk);
    check("rstmid_int_wr2", bus_if.interrupt, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_int", bus_if.interrupt, 1'b0);
    check("rstmid_done", bus_if.done, 1'b0);
    rst = 1'b0;
    cpu_drv = 1'b1; cpu_w = 1'b0; cpu_addr = 8'hF1;
    #1;
    check("rstmid_addr_free", bus_if.addr, 8'hF1);
    cpu_drv = 1'b0;
    check_regs("rstmid", 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    check("rstmid_int_idle", bus_if.interrupt, 1'b0);
    check("rstmid_log_count", log_q.size() - base, 4);

    // register write during ARB must be ignored
    cpu_write(8'hF0, 8'h30); cpu_write(8'hF1, 8'h02); cpu_write(8'hF2, 8'h90);
    base = log_q.size();
    cpu_write(8'hF3, 8'h03);
    @(negedge clk);
    check("busy_int_arb", bus_if.interrupt, 1'b1);
    cpu_drv = 1'b1; cpu_w = 1'b1; cpu_addr = 8'hF1; cpu_data = 8'h09;
    @(posedge clk);
    #1;
    cpu_drv = 1'b0;
    wait_done(cyc, int1);
    check("busy_done_cyc", cyc, 5);
    exp_q = '{{1'b0, 8'h90, 8'h77}, {1'b1, 8'h30, 8'h77},
              {1'b0, 8'h91, 8'h88}, {1'b1, 8'h31, 8'h88}};
    check_log("busy", base);
    check_regs("busy", 8'h30, 8'h02, 8'h90, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
